feature_frame_buffer: RTL and testbench



---
 rtl/feature_frame_buffer.sv | 179 +++++++++++++++++
 tb/tb_feature_frame_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_frame_buffer.sv
// feature_frame_buffer: double-buffered byte-to-word assembler for decision-tree
// feature frames. Bytes arrive MSB first; each frame of N_WORDS x WORD_W bits
// fills one of two ping-pong banks and is offered on a valid/ready handshake
// while the other bank fills.
// Optional build macro: FEATBUF_TIMEOUT_EN (abort a stalled partial frame after
// TIMEOUT_CYCLES idle cycles and pulse timeout_err).
module feature_frame_buffer #(
    parameter int N_WORDS        = 20,
    parameter int WORD_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic                        in_sop,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_WORDS*WORD_W-1:0]   out_data,
    output logic                        sop_err,
    output logic                        timeout_err,
    output logic [CNT_W-1:0]            frame_cnt
);

    localparam int BPW     = WORD_W / 8;
    localparam int FB      = N_WORDS * BPW;
    localparam int FRAME_W = N_WORDS * WORD_W;
    localparam int BC_W    = (FB > 1) ? $clog2(FB) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state, state_nxt;
    logic [BC_W-1:0]    byte_cnt, byte_cnt_nxt;
    logic [BC_W-1:0]    wr_idx;
    int                 wr_off;
    logic [FRAME_W-1:0] bank [2];
    logic [1:0]         full;
    logic               wr_ptr, rd_ptr;
    logic               accept, transfer;
    logic               wr_en, complete, sop_err_nxt, abort_to;

    assign in_ready  = !full[wr_ptr];
    assign out_valid = full[rd_ptr];
    assign out_data  = bank[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // Bit offset of frame byte wr_idx: word idx/BPW, MSB-first lane within the word.
    assign wr_off = (int'(wr_idx) / BPW) * WORD_W + (BPW - 1 - int'(wr_idx) % BPW) * 8;

`ifdef FEATBUF_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    assign abort_to = (state == FILL) && !accept && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive idle cycles while a frame is partially filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort_to;
            if (state != FILL || accept || abort_to)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    assign abort_to    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Write FSM state register, byte counter and registered sop_err pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            sop_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            sop_err  <= sop_err_nxt;
        end
    end

    // Write FSM next-state: byte placement, sop restart, frame completion.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        wr_en        = 1'b0;
        wr_idx       = '0;
        complete     = 1'b0;
        sop_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        wr_en = 1'b1;
                        if (FB == 1) begin
                            complete = 1'b1;
                        end else begin
                            state_nxt    = FILL;
                            byte_cnt_nxt = BC_W'(1);
                        end
                    end else begin
                        sop_err_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_sop) begin
                        byte_cnt_nxt = BC_W'(1);
                        sop_err_nxt  = 1'b1;
                        if (FB == 1) complete = 1'b1;
                    end else begin
                        wr_idx = byte_cnt;
                        if (byte_cnt == BC_W'(FB - 1))
                            complete = 1'b1;
                        else
                            byte_cnt_nxt = byte_cnt + BC_W'(1);
                    end
                end else if (abort_to) begin
                    state_nxt    = IDLE;
                    byte_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            state_nxt    = IDLE;
            byte_cnt_nxt = '0;
        end
    end

    // Bank storage: write the accepted byte into its lane of the write bank.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the banks are reset because out_data is a direct view of the read
        // bank and must read all-zero after reset.
        if (rst) begin
            bank[0] <= '0;
            bank[1] <= '0;
        end else if (wr_en) begin
            bank[wr_ptr][wr_off +: 8] <= in_data;
        end
    end

    // Ping-pong flags, pointers and completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 2'b00;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // A completing bank is empty and a transferring bank is full, so the
            // two updates never touch the same flag.
            if (complete) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
                frame_cnt    <= frame_cnt + CNT_W'(1);
            end
            if (transfer) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_feature_frame_buffer.sv
// tb_feature_frame_buffer: directed bench for feature_frame_buffer at the
// default geometry (20 words x 32 bits, 80 bytes per frame).
module tb_feature_frame_buffer;

    localparam int N_WORDS = 20;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 16;
    localparam int FB      = N_WORDS * WORD_W / 8;
    localparam int FRAME_W = N_WORDS * WORD_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'h00;
    logic               in_sop = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [FRAME_W-1:0] out_data;
    logic               sop_err;
    logic               timeout_err;
    logic [CNT_W-1:0]   frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int sop_pulses = 0;
    int to_pulses  = 0;

    feature_frame_buffer #(
        .N_WORDS(N_WORDS), .WORD_W(WORD_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sop_err(sop_err), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (sop_err === 1'b1) sop_pulses++;
        if (timeout_err === 1'b1) to_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic        sop;
        logic [7:0]  data;
        logic        ordy;
        logic        e_in_ready;
        logic        e_out_valid;
        logic        e_sop_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [FRAME_W-1:0] act,
                         input logic [FRAME_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, waiting (bounded) for in_ready.
    task automatic send_byte(input logic [7:0] d, input logic s);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (!in_ready) check("in_ready_wait", {{(FRAME_W-1){1'b0}}, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    // Frame with byte 0 = first and byte k = base + k for k >= 1.
    task automatic send_frame(input logic [7:0] first, input logic [7:0] base,
                              input logic ordy_last);
        for (int k = 0; k < FB; k++) begin
            if (k == FB - 1) out_ready = ordy_last;
            send_byte((k == 0) ? first : 8'(base + k), k == 0);
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [FRAME_W-1:0] model_frame(input logic [7:0] first,
                                                       input logic [7:0] base);
        logic [7:0] b [FB];
        logic [FRAME_W-1:0] f;
        b[0] = first;
        for (int k = 1; k < FB; k++) b[k] = 8'(base + k);
        f = '0;
        for (int i = 0; i < N_WORDS; i++)
            f[i*WORD_W +: WORD_W] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
        return f;
    endfunction

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int s0;
        int t0;
        logic [FRAME_W-1:0] fa, fb, fc;

        //             vld  sop  data   ordy rdy  ov   serr cnt
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",    FRAME_W'(in_ready), 1);
        check("rst_out_valid",   FRAME_W'(out_valid), 0);
        check("rst_out_data",    out_data, '0);
        check("rst_sop_err",     FRAME_W'(sop_err), 0);
        check("rst_timeout_err", FRAME_W'(timeout_err), 0);
        check("rst_frame_cnt",   FRAME_W'(frame_cnt), 0);

        // Table: stray bytes in IDLE and out_ready with nothing valid
        for (int i = 0; i < 6; i++) begin
            in_valid  = vecs[i].vld;
            in_sop    = vecs[i].sop;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            tick();
            check($sformatf("vec%0d_in_ready", i),  FRAME_W'(in_ready),  FRAME_W'(vecs[i].e_in_ready));
            check($sformatf("vec%0d_out_valid", i), FRAME_W'(out_valid), FRAME_W'(vecs[i].e_out_valid));
            check($sformatf("vec%0d_sop_err", i),   FRAME_W'(sop_err),   FRAME_W'(vecs[i].e_sop_err));
            check($sformatf("vec%0d_frame_cnt", i), FRAME_W'(frame_cnt), FRAME_W'(vecs[i].e_cnt));
        end
        in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b0;

        // Frame A: bytes 0x00..0x4F, latency and word placement
        fa = model_frame(8'h00, 8'h00);
        for (int k = 0; k < FB - 1; k++) send_byte(8'(k), k == 0);
        check("a_valid_before_last", FRAME_W'(out_valid), 0);
        send_byte(8'h4F, 1'b0);
        check("a_out_valid", FRAME_W'(out_valid), 1);
        check("a_word0",  FRAME_W'(out_data[31:0]), FRAME_W'(32'h00010203));
        check("a_word19", FRAME_W'(out_data[19*32 +: 32]), FRAME_W'(32'h4C4D4E4F));
        check("a_frame",  out_data, fa);
        check("a_frame_cnt", FRAME_W'(frame_cnt), 1);

        // Frame B fills the second bank; both full blocks input
        fb = model_frame(8'h80, 8'h80);
        send_frame(8'h80, 8'h80, 1'b0);
        check("b_in_ready_low", FRAME_W'(in_ready), 0);
        check("b_frame_cnt", FRAME_W'(frame_cnt), 2);
        check("b_out_still_a", out_data, fa);

        // Frame C first byte is held while both banks are full
        fc = model_frame(8'h40, 8'h40);
        in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h40;
        repeat (3) tick();
        check("c_held_in_ready", FRAME_W'(in_ready), 0);
        check("c_held_cnt", FRAME_W'(frame_cnt), 2);
        pulse_ready();
        check("xfer_in_ready_back", FRAME_W'(in_ready), 1);
        check("xfer_out_valid", FRAME_W'(out_valid), 1);
        check("xfer_out_b", out_data, fb);
        send_frame(8'h40, 8'h40, 1'b0);
        check("c_frame_cnt", FRAME_W'(frame_cnt), 3);
        check("c_out_still_b", out_data, fb);
        check("c_in_ready_low", FRAME_W'(in_ready), 0);
        pulse_ready();
        check("c_out_valid", FRAME_W'(out_valid), 1);
        check("c_out_data", out_data, fc);
        pulse_ready();
        check("drain_out_valid", FRAME_W'(out_valid), 0);
        check("drain_in_ready", FRAME_W'(in_ready), 1);

        // Mid-frame sop restart
        s0 = sop_pulses;
        for (int k = 0; k < 10; k++) send_byte(8'(8'h10 + k), k == 0);
        send_frame(8'hAA, 8'h00, 1'b0);
        tick();
        check("restart_sop_pulses", FRAME_W'(sop_pulses - s0), 1);
        check("restart_frame_cnt", FRAME_W'(frame_cnt), 4);
        check("restart_word0", FRAME_W'(out_data[31:0]), FRAME_W'(32'hAA010203));
        check("restart_frame", out_data, model_frame(8'hAA, 8'h00));
        pulse_ready();
        check("restart_drained", FRAME_W'(out_valid), 0);

        // Completion in one bank while the other transfers on the same edge
        send_frame(8'h60, 8'h60, 1'b0);
        send_frame(8'h11, 8'h11, 1'b1);
        check("simul_out_valid", FRAME_W'(out_valid), 1);
        check("simul_in_ready", FRAME_W'(in_ready), 1);
        check("simul_out_data", out_data, model_frame(8'h11, 8'h11));
        check("simul_frame_cnt", FRAME_W'(frame_cnt), 6);

        // Asynchronous reset mid-frame with a completed frame still pending
        for (int k = 0; k < 40; k++) send_byte(8'(8'hC0 + k), k == 0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready",  FRAME_W'(in_ready), 1);
        check("arst_out_valid", FRAME_W'(out_valid), 0);
        check("arst_out_data",  out_data, '0);
        check("arst_frame_cnt", FRAME_W'(frame_cnt), 0);
        check("arst_sop_err",   FRAME_W'(sop_err), 0);
        tick();
        rst = 1'b0;
        tick();
        send_frame(8'h20, 8'h20, 1'b0);
        check("post_rst_frame", out_data, model_frame(8'h20, 8'h20));
        check("post_rst_cnt", FRAME_W'(frame_cnt), 1);
        pulse_ready();

        // Partial frame followed by a long idle gap
        t0 = to_pulses;
        for (int k = 0; k < 5; k++) send_byte(8'(8'hE0 + k), k == 0);
        repeat (20) tick();
`ifdef FEATBUF_TIMEOUT_EN
        check("idle_timeout_pulses", FRAME_W'(to_pulses - t0), 1);
`else
        check("idle_timeout_pulses", FRAME_W'(to_pulses - t0), 0);
`endif
        check("idle_frame_cnt", FRAME_W'(frame_cnt), 1);
        check("idle_out_valid", FRAME_W'(out_valid), 0);
        send_frame(8'h33, 8'h33, 1'b0);
        check("idle_next_frame", out_data, model_frame(8'h33, 8'h33));
        check("idle_next_cnt", FRAME_W'(frame_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
